// File: rtl/gear_shifter_pkg.sv
// gear_shifter_pkg
//   Shared definitions for the gear shifter slice: gear range, rpm width,
//   default shift-window bounds, shift quality codes, FSM state encoding and
//   the rpm grading helper.
package gear_shifter_pkg;

  localparam int RPM_W          = 14;
  localparam int GEAR_W         = 2;
  localparam logic [GEAR_W-1:0] GEAR_MAX = 2'd3;

  localparam int SHIFT_LO_DEF   = 7000;
  localparam int SHIFT_HI_DEF   = 9500;

  typedef enum logic [1:0] {
    Q_NONE    = 2'd0,
    Q_EARLY   = 2'd1,
    Q_PERFECT = 2'd2,
    Q_LATE    = 2'd3
  } quality_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  // Unsigned grading of an rpm sample against an inclusive [lo, hi] window.
  function automatic quality_e grade(input logic [RPM_W-1:0] rpm,
                                     input logic [RPM_W-1:0] lo,
                                     input logic [RPM_W-1:0] hi);
    if (rpm < lo)       return Q_EARLY;
    else if (rpm <= hi) return Q_PERFECT;
    else                return Q_LATE;
  endfunction

endpackage

// File: rtl/gear_shifter_if.sv
// gear_shifter_if
//   Gear request/acknowledge link between the gear shifter (master) and the
//   rpm block (slave).
//   Handshake: gear is the request and changes only on an accepted shift.
//   The request is outstanding until gear_ack (the rpm block's registered
//   echo of gear) equals gear; the master holds gear stable while waiting and
//   does not issue a new request until the acknowledge plus lockout is done.
//   Signals:
//     gear      master->slave  2   requested gear 0..3
//     gear_ack  slave->master  2   echo of the accepted gear
//     rpm       slave->master  14  current engine rpm
interface gear_shifter_if;
  import gear_shifter_pkg::*;

  logic [GEAR_W-1:0] gear;
  logic [GEAR_W-1:0] gear_ack;
  logic [RPM_W-1:0]  rpm;

  modport master (output gear, input gear_ack, input rpm);
  modport slave  (input gear, output gear_ack, output rpm);

endinterface

// File: rtl/gear_shifter_key_debounce.sv
// key_debounce
//   Debounces a raw asynchronous key. Two-flop synchroniser followed by a
//   stability counter: the filtered level follows the synchronised key only
//   after DEBOUNCE_TICKS consecutive samples that differ from the current
//   level; a matching sample restarts the count.
//   Ports:
//     clk100Hz  in   tick clock
//     rst_n     in   asynchronous active-low reset
//     key_raw   in   raw bouncing key
//     level     out  filtered key level
//     press     out  1-cycle pulse in the cycle before level rises 0->1
module key_debounce #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic clk100Hz,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk100Hz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Decoded from registers only: high exactly when the next edge will flip
  // level from 0 to 1, so a consumer registering it acts on that same edge.
  assign press = sync2 & ~level & (cnt == LAST);

endmodule

// File: rtl/gear_shifter.sv
// gear_shifter
//   Turns the debounced shift-up key into a gear request, waits for the rpm
//   block to acknowledge it, then holds off further presses for a lockout
//   period. Each accepted shift is graded from the rpm of that cycle. Also
//   drives the cockpit shift light.
//   Ports:
//     clk100Hz       in   tick clock
//     rst_n          in   asynchronous active-low reset
//     shift_up_key   in   raw shift-up key
//     reset_status   in   synchronous race restart
//     bus            master modport: gear out, gear_ack / rpm in
//     shift_busy     out  high in WAIT_ACK or LOCKOUT
//     shift_event    out  1-cycle pulse per accepted shift
//     shift_quality  out  grade of the last shift (quality_e codes)
//     shift_led      out  rpm inside the shift window and gear < 3
//     shift_fault    out  sticky acknowledge-timeout flag
//     dbg_state      out  current FSM state
//     dbg_key_level  out  filtered key level
module gear_shifter
  import gear_shifter_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int LOCKOUT_TICKS  = 50,
  parameter int ACK_TIMEOUT    = 4,
  parameter int SHIFT_LO       = SHIFT_LO_DEF,
  parameter int SHIFT_HI       = SHIFT_HI_DEF
) (
  input  logic                  clk100Hz,
  input  logic                  rst_n,
  input  logic                  shift_up_key,
  input  logic                  reset_status,
  gear_shifter_if.master        bus,
  output logic                  shift_busy,
  output logic                  shift_event,
  output logic [1:0]            shift_quality,
  output logic                  shift_led,
  output logic                  shift_fault,
  output state_e                dbg_state,
  output logic                  dbg_key_level
);

  // One counter serves both the ack timeout and the lockout.
  localparam int CNT_MAX = (LOCKOUT_TICKS > ACK_TIMEOUT) ? LOCKOUT_TICKS : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [RPM_W-1:0] LO        = RPM_W'(SHIFT_LO);
  localparam logic [RPM_W-1:0] HI        = RPM_W'(SHIFT_HI);

  state_e            state;
  logic [GEAR_W-1:0] gear_q;
  quality_e          quality_q;
  logic              event_q;
  logic              busy_q;
  logic              fault_q;
  logic              led_q;
  logic [CNT_W-1:0]  cnt;
  logic              press;
  logic              key_level;

  key_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_key_debounce (
    .clk100Hz (clk100Hz),
    .rst_n    (rst_n),
    .key_raw  (shift_up_key),
    .level    (key_level),
    .press    (press)
  );

  always_ff @(posedge clk100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gear_q    <= '0;
      quality_q <= Q_NONE;
      event_q   <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      led_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      event_q <= 1'b0;
      led_q   <= (bus.rpm >= LO) && (bus.rpm <= HI) && (gear_q != GEAR_MAX);
      if (reset_status) begin
        state     <= ST_IDLE;
        gear_q    <= '0;
        quality_q <= Q_NONE;
        fault_q   <= 1'b0;
        busy_q    <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Presses at top gear are ignored outright.
            if (press && (gear_q != GEAR_MAX)) begin
              gear_q    <= gear_q + 2'd1;
              quality_q <= grade(bus.rpm, LO, HI);
              event_q   <= 1'b1;
              busy_q    <= 1'b1;
              cnt       <= '0;
              state     <= ST_WAIT_ACK;
            end
          end
          ST_WAIT_ACK: begin
            if (bus.gear_ack == gear_q) begin
              cnt   <= LOCK_LOAD;
              state <= ST_LOCKOUT;
            end else if (cnt == ACK_LAST) begin
              // No acknowledge: flag it but still fall through to lockout
              // so the player is not stuck.
              fault_q <= 1'b1;
              cnt     <= LOCK_LOAD;
              state   <= ST_LOCKOUT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_LOCKOUT: begin
            if (cnt == '0) begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.gear      = gear_q;
  assign shift_busy    = busy_q;
  assign shift_event   = event_q;
  assign shift_quality = quality_q;
  assign shift_fault   = fault_q;
  // The registered light is gated by the live gear so it drops the moment
  // top gear is reached.
  assign shift_led     = led_q & (gear_q != GEAR_MAX);
  assign dbg_state     = state;
  assign dbg_key_level = key_level;

endmodule

// File: tb/tb_gear_shifter.sv
// tb_gear_shifter
//   Directed bench for gear_shifter. The rpm block is modelled by a process
//   that echoes gear onto gear_ack shortly after each clock edge (or holds it
//   at 0 when echoing is disabled).
module tb_gear_shifter;
  import gear_shifter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk100Hz = 1'b0;
  logic rst_n;
  logic shift_up_key;
  logic reset_status;

  always #5 clk100Hz = ~clk100Hz;

  gear_shifter_if bus ();

  logic       shift_busy;
  logic       shift_event;
  logic [1:0] shift_quality;
  logic       shift_led;
  logic       shift_fault;
  state_e     dbg_state;
  logic       dbg_key_level;

  gear_shifter dut (
    .clk100Hz      (clk100Hz),
    .rst_n         (rst_n),
    .shift_up_key  (shift_up_key),
    .reset_status  (reset_status),
    .bus           (bus),
    .shift_busy    (shift_busy),
    .shift_event   (shift_event),
    .shift_quality (shift_quality),
    .shift_led     (shift_led),
    .shift_fault   (shift_fault),
    .dbg_state     (dbg_state),
    .dbg_key_level (dbg_key_level)
  );

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  bit ack_follow = 1'b1;

  // rpm-block model: acknowledge visible in the cycle after a gear change.
  always @(posedge clk100Hz) begin
    #1;
    bus.gear_ack = ack_follow ? bus.gear : 2'd0;
  end

  always @(negedge clk100Hz) if (shift_event === 1'b1) ev_cnt++;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk100Hz);
      #1;
    end
  endtask

  // Press the key and wait (bounded) for the accepted-shift pulse.
  task automatic press_wait(output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    shift_up_key = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      n++;
      if (shift_event === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && shift_busy === 1'b1; i++) tick();
    total++;
    if (shift_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: shift_busy=%0b required 0", shift_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++;
    if ({bus.gear, shift_quality, shift_busy, shift_event, shift_led, shift_fault} !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: gear=%0d q=%0d busy=%0b ev=%0b led=%0b fault=%0b required all 0",
               bus.gear, shift_quality, shift_busy, shift_event, shift_led, shift_fault);
    end
    rst_n = 1'b1;
    tick(2);
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    int n;
    int ev0;
    ev0 = ev_cnt;
    bus.rpm = 14'd5000;
    for (int i = 0; i < 6; i++) begin
      shift_up_key = ~shift_up_key;
      tick(3);
    end
    press_wait(seen, n);
    shift_up_key = 1'b0;
    total++;
    if (!seen || n != 10) begin
      bad++;
      $display("FAIL bounce_latency: seen=%0b cycles=%0d required seen=1 cycles=10", seen, n);
    end
    total++;
    if (bus.gear !== 2'd1 || shift_quality !== 2'd1) begin
      bad++;
      $display("FAIL bounce_gear_quality: gear=%0d q=%0d required gear=1 q=1", bus.gear, shift_quality);
    end
    wait_idle();
    total++;
    if (ev_cnt - ev0 != 1) begin
      bad++;
      $display("FAIL bounce_events: events=%0d required 1", ev_cnt - ev0);
    end
  endtask

  task automatic test_good_shift();
    bit seen;
    int n;
    int ev0;
    int busy_cnt;
    ev0 = ev_cnt;
    bus.rpm = 14'd8000;
    press_wait(seen, n);
    total++;
    if (!seen || bus.gear !== 2'd2 || shift_quality !== 2'd2) begin
      bad++;
      $display("FAIL good_shift: seen=%0b gear=%0d q=%0d required seen=1 gear=2 q=2",
               seen, bus.gear, shift_quality);
    end
    // Count busy cycles; meanwhile release and press again inside lockout.
    busy_cnt = 0;
    for (int i = 0; i < 80 && shift_busy === 1'b1; i++) begin
      busy_cnt++;
      if (i == 1)  shift_up_key = 1'b0;
      if (i == 13) shift_up_key = 1'b1;
      if (i == 30) shift_up_key = 1'b0;
      tick();
    end
    total++;
    if (busy_cnt != 51) begin
      bad++;
      $display("FAIL busy_length: cycles=%0d required 51", busy_cnt);
    end
    tick(5);
    total++;
    if (ev_cnt - ev0 != 1 || bus.gear !== 2'd2) begin
      bad++;
      $display("FAIL lockout_drop: events=%0d gear=%0d required events=1 gear=2", ev_cnt - ev0, bus.gear);
    end
  endtask

  task automatic test_led();
    logic [13:0] rpm_v [4] = '{14'd7000, 14'd6999, 14'd9500, 14'd9501};
    logic        exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.rpm = rpm_v[i];
      tick();
      total++;
      if (shift_led !== exp_v[i]) begin
        bad++;
        $display("FAIL led_gear2: rpm=%0d led=%0b required %0b", rpm_v[i], shift_led, exp_v[i]);
      end
    end
  endtask

  task automatic test_late_and_top_gear();
    bit seen;
    int n;
    int ev0;
    bus.rpm = 14'd9501;
    press_wait(seen, n);
    shift_up_key = 1'b0;
    total++;
    if (!seen || bus.gear !== 2'd3 || shift_quality !== 2'd3) begin
      bad++;
      $display("FAIL late_shift: seen=%0b gear=%0d q=%0d required seen=1 gear=3 q=3",
               seen, bus.gear, shift_quality);
    end
    wait_idle();
    bus.rpm = 14'd7000;
    tick(2);
    total++;
    if (shift_led !== 1'b0) begin
      bad++;
      $display("FAIL led_gear3: led=%0b required 0", shift_led);
    end
    ev0 = ev_cnt;
    shift_up_key = 1'b1;
    tick(15);
    shift_up_key = 1'b0;
    tick(12);
    total++;
    if (ev_cnt != ev0 || bus.gear !== 2'd3 || shift_quality !== 2'd3 || shift_busy !== 1'b0) begin
      bad++;
      $display("FAIL top_gear_drop: events=%0d gear=%0d q=%0d busy=%0b required 0/3/3/0",
               ev_cnt - ev0, bus.gear, shift_quality, shift_busy);
    end
  endtask

  task automatic test_reset_status();
    int ev0;
    reset_status = 1'b1;
    tick();
    reset_status = 1'b0;
    total++;
    if (bus.gear !== 2'd0 || shift_quality !== 2'd0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL status_clear: gear=%0d q=%0d state=%0d required 0/0/0",
               bus.gear, shift_quality, dbg_state);
    end
    // Press pulse lands on the 10th edge after the key rises; restart on that edge.
    ev0 = ev_cnt;
    bus.rpm = 14'd8000;
    shift_up_key = 1'b1;
    tick(9);
    reset_status = 1'b1;
    tick();
    reset_status = 1'b0;
    total++;
    if (bus.gear !== 2'd0 || shift_event !== 1'b0 || shift_quality !== 2'd0) begin
      bad++;
      $display("FAIL status_vs_press: gear=%0d ev=%0b q=%0d required 0/0/0",
               bus.gear, shift_event, shift_quality);
    end
    tick(20);
    total++;
    if (ev_cnt != ev0 || bus.gear !== 2'd0) begin
      bad++;
      $display("FAIL held_key_after_status: events=%0d gear=%0d required 0/0", ev_cnt - ev0, bus.gear);
    end
    shift_up_key = 1'b0;
    tick(12);
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    ack_follow = 1'b0;
    tick(2);
    press_wait(seen, n);
    shift_up_key = 1'b0;
    total++;
    if (!seen || bus.gear !== 2'd1) begin
      bad++;
      $display("FAIL timeout_shift: seen=%0b gear=%0d required seen=1 gear=1", seen, bus.gear);
    end
    tick(3);
    total++;
    if (shift_fault !== 1'b0 || dbg_state !== ST_WAIT_ACK) begin
      bad++;
      $display("FAIL timeout_early: fault=%0b state=%0d required 0/%0d", shift_fault, dbg_state, ST_WAIT_ACK);
    end
    tick();
    total++;
    if (shift_fault !== 1'b1 || dbg_state !== ST_LOCKOUT || shift_busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fire: fault=%0b state=%0d busy=%0b required 1/%0d/1",
               shift_fault, dbg_state, shift_busy, ST_LOCKOUT);
    end
    wait_idle();
    tick(3);
    total++;
    if (shift_fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_sticky: fault=%0b required 1", shift_fault);
    end
    reset_status = 1'b1;
    tick();
    reset_status = 1'b0;
    ack_follow = 1'b1;
    total++;
    if (shift_fault !== 1'b0 || bus.gear !== 2'd0) begin
      bad++;
      $display("FAIL fault_clear: fault=%0b gear=%0d required 0/0", shift_fault, bus.gear);
    end
    tick(2);
  endtask

  task automatic test_async_reset();
    bit seen;
    int n;
    bus.rpm = 14'd8000;
    press_wait(seen, n);
    shift_up_key = 1'b0;
    wait_idle();
    tick(2);
    press_wait(seen, n);
    shift_up_key = 1'b0;
    tick(10);
    total++;
    if (dbg_state !== ST_LOCKOUT || bus.gear !== 2'd2 || shift_led !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: state=%0d gear=%0d led=%0b required %0d/2/1",
               dbg_state, bus.gear, shift_led, ST_LOCKOUT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.gear, shift_quality, shift_busy, shift_event, shift_led, shift_fault} !== 8'd0 ||
        dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL async_reset: gear=%0d q=%0d busy=%0b led=%0b state=%0d required all 0",
               bus.gear, shift_quality, shift_busy, shift_led, dbg_state);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    total++;
    if (dbg_state !== ST_IDLE || bus.gear !== 2'd0 || shift_busy !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: state=%0d gear=%0d busy=%0b required 0/0/0",
               dbg_state, bus.gear, shift_busy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    shift_up_key = 1'b0;
    reset_status = 1'b0;
    bus.rpm      = 14'd0;
    test_reset();
    test_bounce();
    test_good_shift();
    test_led();
    test_late_and_top_gear();
    test_reset_status();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
